wb_timeout_intercon: RTL and testbench
======================================

Name: wb_timeout_intercon

Overview:
Parametrised single-master, N-slave Wishbone interconnect with registered address decode and a per-transaction ACK watchdog. It sits between the multi-cycle CPU bus signals (STB/WE/ADDR/DAT) and the RAM, disk, VRAM, keyboard and counter slaves. A slave that never ACKs, or an unmapped address, completes with an error response instead of hanging the CPU. This replaces the manual ACK override switch used today.

Parameters:
SLAVES, 5, number of slave ports (1..2**IDX_W)
IDX_W, 4, width of the slave-select field
SEL_LO, 28, LSB of the slave-select field in master_ADDR; index = master_ADDR[SEL_LO+IDX_W-1:SEL_LO]
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, cycles to wait for slave ACK before erroring (1..65535)
ERR_DATA, 32'hDEADBEEF, read data returned on error

Ports:
clk  in  1  bus clock
rst  in  1  asynchronous active-high reset
master_STB  in  1  master request, held until master_ACK is seen
master_WE  in  1  1 = write
master_ADDR  in  ADDR_W  byte address
master_DAT_I  in  DATA_W  write data from master
master_DAT_O  out  DATA_W  read data to master
master_ACK  out  1  one-cycle completion pulse
master_ERR  out  1  high with master_ACK when the transaction faulted
slave_STB  out  SLAVES  one-hot strobe
slave_WE  out  1  registered WE
slave_ADDR  out  ADDR_W  registered address
slave_DAT_O  out  DATA_W  registered write data
slave_DAT_I  in  SLAVES*DATA_W  concatenated slave read data; slave k at [k*DATA_W +: DATA_W]
slave_ACK  in  SLAVES  slave acknowledges
fault_idx  out  IDX_W  index of the most recent faulting transaction
fault_count  out  8  saturating fault counter
err_clr  in  1  clears fault_count and fault_idx

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0. This covers slave_STB, master_ACK, master_ERR, master_DAT_O, slave_WE/ADDR/DAT_O, fault_idx, fault_count and the watchdog counter.
- States: IDLE, BUSY, RESP, RELEASE.
- IDLE, master_STB=1:
  - Latch ADDR, WE and DAT_I into the slave_* registers.
  - Decode the index.
  - Index < SLAVES: go to BUSY and assert slave_STB[idx] from the next cycle.
  - Index >= SLAVES: go to RESP with the error flag set; no slave strobed.
- BUSY:
  - slave_STB[idx] held; watchdog increments each cycle.
  - slave_ACK[idx]=1: capture slave_DAT_I[idx] into master_DAT_O, drop slave_STB, go to RESP with no error. ACK on any other bit is ignored.
  - Watchdog reaches TIMEOUT with no ACK: drop slave_STB, master_DAT_O=ERR_DATA, go to RESP with error.
  - ACK and timeout in the same cycle: ACK wins.
- RESP:
  - master_ACK=1 for exactly one cycle; master_ERR = error flag.
  - On error: fault_idx <= idx; fault_count += 1, saturating at 255.
  - Go to RELEASE.
- RELEASE:
  - Wait for master_STB=0, then go to IDLE. This blocks back-to-back re-issue from a held strobe.
  - master_DAT_O keeps its value until the next RESP.
- Latency: a mapped slave with combinational ACK gives master_ACK 2 cycles after STB is sampled (IDLE→BUSY→RESP). Unmapped: 1 cycle.
- Writes with error: the slave may or may not have taken the write; the master only sees ERR.
- master_STB dropping mid-BUSY: the transaction still completes; the ACK is issued anyway.
- err_clr: has priority over a same-cycle fault increment. Counter is cleared; fault_idx=0.
- Reset mid-transaction: slave_STB drops immediately (async). The CPU must be reset with it.
- Watchdog width: clog2(TIMEOUT+1); cleared on entry to BUSY.

Optional Feature:
WB_ERR_INT_EN: adds output err_int (1 bit).
- Set in RESP when the error flag is 1; cleared by err_clr or rst.
- Level output, suitable for OR-ing into the CPU interrupt with its own cause code.
- Without the macro, the port does not exist and no interrupt logic is built.

Test Plan:
- Read from slave 0 (ADDR=32'h0000_0010) with ACK tied high and DAT 32'h1234_5678 → slave_STB=5'b00001 one cycle after STB. master_ACK pulses 2 cycles after STB with DAT_O=32'h1234_5678 and ERR=0.
- Write to slave 2 (ADDR=32'h2000_0004, DAT 32'hA5) with ACK delayed 10 cycles → slave_WE=1, slave_DAT_O=32'hA5, slave_STB[2] held 10 cycles, then master_ACK once with ERR=0.
- Slave 1 never ACKs, TIMEOUT=255 → master_ACK and ERR at BUSY+255, DAT_O=32'hDEADBEEF, fault_idx=1, fault_count=1.
- Access ADDR=32'h7000_0000 (idx 7, unmapped) → no slave_STB; ACK+ERR next cycle; fault_idx=7.
- Hold master_STB high for 20 cycles after ACK → only one ACK and one slave_STB burst. Drop STB → IDLE, and the next STB is accepted.
- rst pulsed in BUSY → slave_STB=0 immediately. Then 256 timeouts → fault_count stays 255; err_clr → 0; err_int (WB_ERR_INT_EN) cleared.

Source files
------------

// File: rtl/wb_timeout_intercon_if.sv
// ============================================================================
// wb_timeout_intercon_if : Wishbone bus bundle between the CPU, the
//                          watchdog interconnect and its slaves.
// Rev 1.0
// ============================================================================
`default_nettype none

interface wb_timeout_intercon_if #(
  parameter int SLAVES = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                     master_STB;
  logic                     master_WE;
  logic [ADDR_W-1:0]        master_ADDR;
  logic [DATA_W-1:0]        master_DAT_I;
  logic [DATA_W-1:0]        master_DAT_O;
  logic                     master_ACK;
  logic                     master_ERR;

  logic [SLAVES-1:0]        slave_STB;
  logic                     slave_WE;
  logic [ADDR_W-1:0]        slave_ADDR;
  logic [DATA_W-1:0]        slave_DAT_O;
  logic [SLAVES*DATA_W-1:0] slave_DAT_I;
  logic [SLAVES-1:0]        slave_ACK;

  // CPU-side view of the bus.
  modport master (
    output master_STB, master_WE, master_ADDR, master_DAT_I,
    input  master_DAT_O, master_ACK, master_ERR
  );

  // Slave-side view of the bus.
  modport slave (
    input  slave_STB, slave_WE, slave_ADDR, slave_DAT_O,
    output slave_DAT_I, slave_ACK
  );

  // Interconnect view: bridges the two sides.
  modport intercon (
    input  master_STB, master_WE, master_ADDR, master_DAT_I,
    output master_DAT_O, master_ACK, master_ERR,
    output slave_STB, slave_WE, slave_ADDR, slave_DAT_O,
    input  slave_DAT_I, slave_ACK
  );
endinterface

`default_nettype wire

// File: rtl/wb_timeout_intercon.sv
// ============================================================================
// wb_timeout_intercon : single-master, N-slave Wishbone interconnect with
//                       registered decode and per-transaction ACK watchdog.
//                       Optional WB_ERR_INT_EN adds a level fault interrupt.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_timeout_intercon #(
  parameter int                 SLAVES   = 5,
  parameter int                 IDX_W    = 4,
  parameter int                 SEL_LO   = 28,
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  wire logic               clk,
  input  wire logic               rst,
  wb_timeout_intercon_if.intercon bus,
  output logic [IDX_W-1:0]        fault_idx,
  output logic [7:0]              fault_count,
  input  wire logic               err_clr
`ifdef WB_ERR_INT_EN
  ,
  output logic                    err_int
`endif
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WD_W-1:0]   wd;
  logic              err_flag;

  logic [IDX_W-1:0]  req_idx;
  logic              req_mapped;
  logic              sel_ack;
  logic [DATA_W-1:0] sel_dat;

  assign req_idx    = bus.master_ADDR[SEL_LO +: IDX_W];
  assign req_mapped = ({1'b0, req_idx} < (IDX_W + 1)'(SLAVES));

  // Only the selected slave's ACK and data are observed; stray ACKs are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < SLAVES; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_ack = bus.slave_ACK[k];
        sel_dat = bus.slave_DAT_I[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      wd               <= '0;
      err_flag         <= 1'b0;
      bus.slave_STB    <= '0;
      bus.slave_WE     <= 1'b0;
      bus.slave_ADDR   <= '0;
      bus.slave_DAT_O  <= '0;
      bus.master_DAT_O <= '0;
      bus.master_ACK   <= 1'b0;
      bus.master_ERR   <= 1'b0;
      fault_idx        <= '0;
      fault_count      <= '0;
`ifdef WB_ERR_INT_EN
      err_int          <= 1'b0;
`endif
    end else begin
      bus.master_ACK <= 1'b0;
      bus.master_ERR <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.master_STB) begin
            bus.slave_WE    <= bus.master_WE;
            bus.slave_ADDR  <= bus.master_ADDR;
            bus.slave_DAT_O <= bus.master_DAT_I;
            idx             <= req_idx;
            wd              <= '0;
            if (req_mapped) begin
              state         <= BUSY;
              err_flag      <= 1'b0;
              bus.slave_STB <= SLAVES'(1) << req_idx;
            end else begin
              // Unmapped: answer straight away with an error.
              state            <= RESP;
              err_flag         <= 1'b1;
              bus.master_ACK   <= 1'b1;
              bus.master_ERR   <= 1'b1;
              bus.master_DAT_O <= ERR_DATA;
            end
          end
        end

        BUSY: begin
          if (sel_ack) begin
            state            <= RESP;
            err_flag         <= 1'b0;
            bus.slave_STB    <= '0;
            bus.master_DAT_O <= sel_dat;
            bus.master_ACK   <= 1'b1;
          end else if (wd == WD_LAST) begin
            state            <= RESP;
            err_flag         <= 1'b1;
            bus.slave_STB    <= '0;
            bus.master_DAT_O <= ERR_DATA;
            bus.master_ACK   <= 1'b1;
            bus.master_ERR   <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        RESP: begin
          state <= RELEASE;
        end

        RELEASE: begin
          // Hold off until the master lets go so a held strobe cannot re-issue.
          if (!bus.master_STB) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (err_clr) begin
        fault_count <= '0;
        fault_idx   <= '0;
`ifdef WB_ERR_INT_EN
        err_int     <= 1'b0;
`endif
      end else if (state == RESP && err_flag) begin
        fault_idx <= idx;
        if (fault_count != 8'hFF) begin
          fault_count <= fault_count + 8'd1;
        end
`ifdef WB_ERR_INT_EN
        err_int <= 1'b1;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_timeout_intercon.sv
// ============================================================================
// tb_wb_timeout_intercon : directed self-checking bench for wb_timeout_intercon.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_timeout_intercon;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic [3:0] fault_idx;
  logic [7:0] fault_count;
`ifdef WB_ERR_INT_EN
  logic       err_int;
`endif

  int passed = 0;
  int total  = 0;

  wb_timeout_intercon_if #(.SLAVES(5), .ADDR_W(32), .DATA_W(32)) bus ();

  wb_timeout_intercon #(
    .SLAVES(5), .IDX_W(4), .SEL_LO(28), .ADDR_W(32), .DATA_W(32),
    .TIMEOUT(255), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fault_idx   (fault_idx),
    .fault_count (fault_count),
    .err_clr     (err_clr)
`ifdef WB_ERR_INT_EN
    ,
    .err_int     (err_int)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    err_clr          = 1'b0;
    bus.master_STB   = 1'b0;
    bus.master_WE    = 1'b0;
    bus.master_ADDR  = '0;
    bus.master_DAT_I = '0;
    bus.slave_ACK    = '0;
    bus.slave_DAT_I  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.slave_STB !== 5'b0) $display("FAIL rst_slave_stb: got %b want 00000", bus.slave_STB); else passed++;
    total++; if ({bus.master_ACK, bus.master_ERR} !== 2'b00) $display("FAIL rst_ack_err: got %b want 00", {bus.master_ACK, bus.master_ERR}); else passed++;
    total++; if (bus.master_DAT_O !== 32'h0) $display("FAIL rst_dat_o: got %h want 00000000", bus.master_DAT_O); else passed++;
    total++; if ({bus.slave_WE, bus.slave_ADDR, bus.slave_DAT_O} !== 65'h0) $display("FAIL rst_slave_regs: got %h want 0", {bus.slave_WE, bus.slave_ADDR, bus.slave_DAT_O}); else passed++;
    total++; if ({fault_idx, fault_count} !== 12'h0) $display("FAIL rst_fault: got %h want 000", {fault_idx, fault_count}); else passed++;
  endtask

  task automatic test_read_slave0();
    bus.slave_ACK             = 5'b00001;
    bus.slave_DAT_I[0 +: 32]  = 32'h1234_5678;
    bus.master_WE             = 1'b0;
    bus.master_ADDR           = 32'h0000_0010;
    bus.master_STB            = 1'b1;
    tick();
    total++; if (bus.slave_STB !== 5'b00001) $display("FAIL rd_slave_stb: got %b want 00001", bus.slave_STB); else passed++;
    total++; if (bus.slave_ADDR !== 32'h0000_0010) $display("FAIL rd_slave_addr: got %h want 00000010", bus.slave_ADDR); else passed++;
    total++; if (bus.master_ACK !== 1'b0) $display("FAIL rd_early_ack: got %b want 0", bus.master_ACK); else passed++;
    tick();
    total++; if ({bus.master_ACK, bus.master_ERR} !== 2'b10) $display("FAIL rd_ack_err: got %b want 10", {bus.master_ACK, bus.master_ERR}); else passed++;
    total++; if (bus.master_DAT_O !== 32'h1234_5678) $display("FAIL rd_data: got %h want 12345678", bus.master_DAT_O); else passed++;
    total++; if (bus.slave_STB !== 5'b0) $display("FAIL rd_stb_drop: got %b want 00000", bus.slave_STB); else passed++;
    bus.master_STB = 1'b0;
    tick();
    total++; if (bus.master_ACK !== 1'b0) $display("FAIL rd_ack_pulse: got %b want 0", bus.master_ACK); else passed++;
    tick();
  endtask

  task automatic test_write_delayed();
    int held;
    bus.slave_ACK    = 5'b00011;
    bus.master_WE    = 1'b1;
    bus.master_ADDR  = 32'h2000_0004;
    bus.master_DAT_I = 32'h0000_00A5;
    bus.master_STB   = 1'b1;
    tick();
    total++; if ({bus.slave_WE, bus.slave_DAT_O} !== {1'b1, 32'h0000_00A5}) $display("FAIL wr_we_dat: got %b/%h want 1/000000a5", bus.slave_WE, bus.slave_DAT_O); else passed++;
    held = (bus.slave_STB == 5'b00100 && !bus.master_ACK) ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (bus.slave_STB == 5'b00100 && !bus.master_ACK) held++;
    end
    total++; if (held !== 10) $display("FAIL wr_stb_held: got %0d want 10", held); else passed++;
    bus.slave_ACK = 5'b00100;
    tick();
    total++; if ({bus.master_ACK, bus.master_ERR} !== 2'b10) $display("FAIL wr_ack_err: got %b want 10", {bus.master_ACK, bus.master_ERR}); else passed++;
    bus.slave_ACK  = 5'b0;
    bus.master_STB = 1'b0;
    bus.master_WE  = 1'b0;
    tick();
    total++; if (bus.master_ACK !== 1'b0) $display("FAIL wr_ack_pulse: got %b want 0", bus.master_ACK); else passed++;
    tick();
  endtask

  task automatic test_timeout();
    int waited;
    bus.slave_ACK   = 5'b0;
    bus.master_ADDR = 32'h1000_0000;
    bus.master_STB  = 1'b1;
    tick();
    total++; if (bus.slave_STB !== 5'b00010) $display("FAIL to_slave_stb: got %b want 00010", bus.slave_STB); else passed++;
    waited = 0;
    while (!bus.master_ACK && waited < 400) begin
      tick();
      waited++;
    end
    total++; if (waited !== 255) $display("FAIL to_latency: got %0d want 255", waited); else passed++;
    total++; if (bus.master_ERR !== 1'b1) $display("FAIL to_err: got %b want 1", bus.master_ERR); else passed++;
    total++; if (bus.master_DAT_O !== 32'hDEADBEEF) $display("FAIL to_data: got %h want deadbeef", bus.master_DAT_O); else passed++;
    bus.master_STB = 1'b0;
    tick();
    total++; if ({fault_idx, fault_count} !== {4'd1, 8'd1}) $display("FAIL to_fault: got idx %0d cnt %0d want idx 1 cnt 1", fault_idx, fault_count); else passed++;
`ifdef WB_ERR_INT_EN
    total++; if (err_int !== 1'b1) $display("FAIL to_err_int: got %b want 1", err_int); else passed++;
`endif
    tick();
  endtask

  task automatic test_unmapped();
    bus.master_ADDR = 32'h7000_0000;
    bus.master_STB  = 1'b1;
    tick();
    total++; if (bus.slave_STB !== 5'b0) $display("FAIL um_slave_stb: got %b want 00000", bus.slave_STB); else passed++;
    total++; if ({bus.master_ACK, bus.master_ERR} !== 2'b11) $display("FAIL um_ack_err: got %b want 11", {bus.master_ACK, bus.master_ERR}); else passed++;
    bus.master_STB = 1'b0;
    tick();
    total++; if ({fault_idx, fault_count} !== {4'd7, 8'd2}) $display("FAIL um_fault: got idx %0d cnt %0d want idx 7 cnt 2", fault_idx, fault_count); else passed++;
    tick();
  endtask

  task automatic test_held_strobe();
    int acks;
    int stbs;
    bus.slave_ACK            = 5'b00001;
    bus.slave_DAT_I[0 +: 32] = 32'hCAFE_0001;
    bus.master_ADDR          = 32'h0000_0020;
    bus.master_STB           = 1'b1;
    acks = 0;
    stbs = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.master_ACK) acks++;
      if (bus.slave_STB != 5'b0) stbs++;
    end
    total++; if (acks !== 1) $display("FAIL held_acks: got %0d want 1", acks); else passed++;
    total++; if (stbs !== 1) $display("FAIL held_stbs: got %0d want 1", stbs); else passed++;
    bus.master_STB = 1'b0;
    tick();
    bus.slave_DAT_I[0 +: 32] = 32'hCAFE_0002;
    bus.master_STB           = 1'b1;
    tick();
    total++; if (bus.slave_STB !== 5'b00001) $display("FAIL held_reissue_stb: got %b want 00001", bus.slave_STB); else passed++;
    tick();
    total++; if ({bus.master_ACK, bus.master_DAT_O} !== {1'b1, 32'hCAFE_0002}) $display("FAIL held_reissue_ack: got %b/%h want 1/cafe0002", bus.master_ACK, bus.master_DAT_O); else passed++;
    bus.master_STB = 1'b0;
    bus.slave_ACK  = 5'b0;
    tick();
    tick();
  endtask

  task automatic test_master_drop();
    bus.slave_ACK   = 5'b0;
    bus.master_ADDR = 32'h3000_0000;
    bus.master_STB  = 1'b1;
    tick();
    bus.master_STB = 1'b0;
    tick();
    tick();
    total++; if (bus.slave_STB !== 5'b01000) $display("FAIL drop_stb_held: got %b want 01000", bus.slave_STB); else passed++;
    bus.slave_ACK = 5'b01000;
    tick();
    total++; if ({bus.master_ACK, bus.master_ERR} !== 2'b10) $display("FAIL drop_ack: got %b want 10", {bus.master_ACK, bus.master_ERR}); else passed++;
    bus.slave_ACK = 5'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_busy();
    bus.master_ADDR = 32'h4000_0000;
    bus.master_STB  = 1'b1;
    tick();
    total++; if (bus.slave_STB !== 5'b10000) $display("FAIL rb_stb_before: got %b want 10000", bus.slave_STB); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.slave_STB !== 5'b0) $display("FAIL rb_async_drop: got %b want 00000", bus.slave_STB); else passed++;
    total++; if (fault_count !== 8'd0) $display("FAIL rb_fault_cnt: got %0d want 0", fault_count); else passed++;
    bus.master_STB = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      bus.master_ADDR = 32'h9000_0000;
      bus.master_STB  = 1'b1;
      tick();
      bus.master_STB = 1'b0;
      tick();
      tick();
      if (i == 254) begin
        total++; if (fault_count !== 8'd255) $display("FAIL sat_255: got %0d want 255", fault_count); else passed++;
      end
    end
    total++; if ({fault_idx, fault_count} !== {4'd9, 8'd255}) $display("FAIL sat_hold: got idx %0d cnt %0d want idx 9 cnt 255", fault_idx, fault_count); else passed++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if ({fault_idx, fault_count} !== 12'h0) $display("FAIL clr: got idx %0d cnt %0d want 0 0", fault_idx, fault_count); else passed++;
`ifdef WB_ERR_INT_EN
    total++; if (err_int !== 1'b0) $display("FAIL clr_err_int: got %b want 0", err_int); else passed++;
`endif
    // Clear coinciding with a fault in RESP must win.
    bus.master_ADDR = 32'hA000_0000;
    bus.master_STB  = 1'b1;
    tick();
    bus.master_STB = 1'b0;
    err_clr        = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (fault_count !== 8'd0) $display("FAIL clr_priority: got %0d want 0", fault_count); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_slave0();
    test_write_delayed();
    test_timeout();
    test_unmapped();
    test_held_strobe();
    test_master_drop();
    test_reset_busy();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
